regfile_wb_arbiter: RTL and testbench

//  Sequences the single regfile_v2 write port between two writeback sources: ALU results and load data (MEM).

---
 rtl/regfile_wb_arbiter_pkg.sv | 19 +
 rtl/regfile_wb_arbiter_wb_slot.sv | 57 +++++
 rtl/regfile_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the regfile writeback arbiter.
// Slot indices are used to address the per-source arrays in the top level.
package regfile_wb_arbiter_pkg;

    localparam int AWIDTH_DEF     = 8;
    localparam int DWIDTH_DEF     = 16;
    localparam int STARVE_MAX_DEF = 3;

    localparam logic [2:0] REG_ZERO_BITS = 3'b000;

    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;

    // Register-file r0 aliasing: any address whose low three bits are zero
    function automatic logic is_zero_reg(input logic [2:0] addr_lo);
        return addr_lo == REG_ZERO_BITS;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// One-entry writeback holding slot: full flag, address, data and an age bit.
// The age bit is 1 when this entry is older than whatever the other slot holds.
module wb_slot
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_clear_n,
    input  logic              i_load,
    input  logic              i_drain,
    input  logic              i_flush,
    input  logic              i_set_old,
    input  logic              i_age,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_data,
    output logic              o_full,
    output logic [AWIDTH-1:0] o_addr,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_old
);

    logic              r_full;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_data;
    logic              r_old;

    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_full <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_old  <= 1'b0;
        end else if (i_flush) begin
            r_full <= 1'b0;
            r_old  <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_addr <= i_addr;
            r_data <= i_data;
            r_old  <= i_age;
        end else begin
            if (i_drain)
                r_full <= 1'b0;
            // A held entry becomes the older one once the other slot reloads
            if (i_set_old)
                r_old <= 1'b1;
        end
    end

    assign o_full = r_full;
    assign o_addr = r_addr;
    assign o_data = r_data;
    assign o_old  = r_old;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single regfile write port,
// with starvation relief, same-address ordering and decode hazard reporting.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int AWIDTH     = AWIDTH_DEF,
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              i_clk,
    input  logic              i_clear_n,
    input  logic              i_flush,
    input  logic              i_alu_valid,
    output logic              o_alu_ready,
    input  logic [AWIDTH-1:0] i_alu_addr,
    input  logic [DWIDTH-1:0] i_alu_data,
    input  logic              i_mem_valid,
    output logic              o_mem_ready,
    input  logic [AWIDTH-1:0] i_mem_addr,
    input  logic [DWIDTH-1:0] i_mem_data,
    input  logic [AWIDTH-1:0] i_qry_rs,
    input  logic [AWIDTH-1:0] i_qry_rt,
    output logic              o_hazard_rs,
    output logic              o_hazard_rt,
    output logic              o_req_rd,
    output logic [AWIDTH-1:0] o_addr_rd,
    output logic [DWIDTH-1:0] o_wdata
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

    logic [1:0]        w_in_valid, w_ready, w_accept, w_load, w_full, w_grant;
    logic [1:0]        w_old, w_age, w_set_old, w_hit_rs, w_hit_rt;
    logic [AWIDTH-1:0] w_in_addr   [2];
    logic [DWIDTH-1:0] w_in_data   [2];
    logic [AWIDTH-1:0] w_slot_addr [2];
    logic [DWIDTH-1:0] w_slot_data [2];

    logic [SW-1:0]     r_starve;
    logic              r_req_rd;
    logic [AWIDTH-1:0] r_addr_rd;
    logic [DWIDTH-1:0] r_wdata;

    assign w_in_valid[SRC_ALU] = i_alu_valid;
    assign w_in_valid[SRC_MEM] = i_mem_valid;
    assign w_in_addr[SRC_ALU]  = i_alu_addr;
    assign w_in_addr[SRC_MEM]  = i_mem_addr;
    assign w_in_data[SRC_ALU]  = i_alu_data;
    assign w_in_data[SRC_MEM]  = i_mem_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign w_ready[gi]   = i_clear_n & ~i_flush & (~w_full[gi] | w_grant[gi]);
            assign w_accept[gi]  = w_in_valid[gi] & w_ready[gi];
            assign w_load[gi]    = w_accept[gi] & ~is_zero_reg(w_in_addr[gi][2:0]);
            assign w_set_old[gi] = w_load[1-gi];
            // Younger if the other slot keeps its entry; on a tie the ALU beat is younger
            assign w_age[gi]     = ~(w_full[1-gi] & ~w_grant[1-gi]) &
                                   ((gi == SRC_ALU) ? ~w_load[1-gi] : 1'b1);
            assign w_hit_rs[gi]  = w_full[gi] & ~w_grant[gi] & (w_slot_addr[gi] == i_qry_rs);
            assign w_hit_rt[gi]  = w_full[gi] & ~w_grant[gi] & (w_slot_addr[gi] == i_qry_rt);

            wb_slot #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_slot (
                .i_clk     (i_clk),
                .i_clear_n (i_clear_n),
                .i_load    (w_load[gi]),
                .i_drain   (w_grant[gi]),
                .i_flush   (i_flush),
                .i_set_old (w_set_old[gi]),
                .i_age     (w_age[gi]),
                .i_addr    (w_in_addr[gi]),
                .i_data    (w_in_data[gi]),
                .o_full    (w_full[gi]),
                .o_addr    (w_slot_addr[gi]),
                .o_data    (w_slot_data[gi]),
                .o_old     (w_old[gi])
            );
        end
    endgenerate

    always_comb begin
        w_grant = '0;
        if (!i_flush) begin
            if (w_full[SRC_ALU] && w_full[SRC_MEM] &&
                w_slot_addr[SRC_ALU] == w_slot_addr[SRC_MEM]) begin
                if (w_old[SRC_ALU] && !w_old[SRC_MEM])
                    w_grant[SRC_ALU] = 1'b1;
                else
                    w_grant[SRC_MEM] = 1'b1;
            end else if (w_full[SRC_ALU] && r_starve == STARVE_LIM) begin
                w_grant[SRC_ALU] = 1'b1;
            end else if (w_full[SRC_MEM]) begin
                w_grant[SRC_MEM] = 1'b1;
            end else if (w_full[SRC_ALU]) begin
                w_grant[SRC_ALU] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_starve <= '0;
        end else if (i_flush || w_grant[SRC_ALU]) begin
            r_starve <= '0;
        end else if (w_full[SRC_ALU] && r_starve != STARVE_LIM) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Address/data hold their last value between grants; only req_rd pulses
    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_req_rd  <= 1'b0;
            r_addr_rd <= '0;
            r_wdata   <= '0;
        end else begin
            r_req_rd <= |w_grant;
            if (|w_grant) begin
                r_addr_rd <= w_grant[SRC_ALU] ? w_slot_addr[SRC_ALU] : w_slot_addr[SRC_MEM];
                r_wdata   <= w_grant[SRC_ALU] ? w_slot_data[SRC_ALU] : w_slot_data[SRC_MEM];
            end
        end
    end

    assign o_alu_ready = w_ready[SRC_ALU];
    assign o_mem_ready = w_ready[SRC_MEM];
    assign o_hazard_rs = i_clear_n & ~is_zero_reg(i_qry_rs[2:0]) & (|w_hit_rs);
    assign o_hazard_rt = i_clear_n & ~is_zero_reg(i_qry_rt[2:0]) & (|w_hit_rt);
    assign o_req_rd    = r_req_rd;
    assign o_addr_rd   = r_addr_rd;
    assign o_wdata     = r_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected regfile writes are queued
// as stimulus is driven and popped by a write monitor.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        clear_n, flush;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [7:0]  alu_addr, mem_addr, qry_rs, qry_rt, addr_rd;
    logic [15:0] alu_data, mem_data, wdata;
    logic        hazard_rs, hazard_rt, req_rd;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [15:0] model_rf [256];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .i_clk       (clk),
        .i_clear_n   (clear_n),
        .i_flush     (flush),
        .i_alu_valid (alu_valid),
        .o_alu_ready (alu_ready),
        .i_alu_addr  (alu_addr),
        .i_alu_data  (alu_data),
        .i_mem_valid (mem_valid),
        .o_mem_ready (mem_ready),
        .i_mem_addr  (mem_addr),
        .i_mem_data  (mem_data),
        .i_qry_rs    (qry_rs),
        .i_qry_rt    (qry_rt),
        .o_hazard_rs (hazard_rs),
        .o_hazard_rt (hazard_rt),
        .o_req_rd    (req_rd),
        .o_addr_rd   (addr_rd),
        .o_wdata     (wdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every regfile write must match the head of the queue
    always @(negedge clk) begin
        if (clear_n && req_rd) begin
            model_rf[addr_rd] = wdata;
            check("wr_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wr_addr_data", {8'd0, addr_rd, wdata}, {8'd0, mon_e.a, mon_e.d});
                $display("write r%0d <= %04h (expected r%0d <= %04h)", addr_rd, wdata, mon_e.a, mon_e.d);
            end
        end
    end

    initial begin
        int   ai, mi;
        logic acc_a, acc_m;
        for (int i = 0; i < 256; i++) model_rf[i] = 16'h0;
        clear_n = 1'b0; flush = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_addr = '0; mem_addr = '0; alu_data = '0; mem_data = '0;
        qry_rs = 8'd1; qry_rt = 8'd2;

        // Reset state
        repeat (2) tick();
        check("rst_req_rd", 32'(req_rd), 32'd0);
        check("rst_addr_rd", 32'(addr_rd), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_hazard_rs", 32'(hazard_rs), 32'd0);
        clear_n = 1'b1;
        #1;
        check("rel_alu_ready", 32'(alu_ready), 32'd1);
        check("rel_mem_ready", 32'(mem_ready), 32'd1);

        // Single ALU beat: write visible only in the cycle after edge k+1
        tick();
        alu_valid = 1'b1; alu_addr = 8'd5; alu_data = 16'h1234;
        exp_q.push_back(wr_t'{a: 8'd5, d: 16'h1234});
        tick();
        alu_valid = 1'b0;
        check("t2_cycle_k_req", 32'(req_rd), 32'd0);
        tick();
        check("t2_req", 32'(req_rd), 32'd1);
        check("t2_addr", 32'(addr_rd), 32'd5);
        check("t2_data", 32'(wdata), 32'h1234);
        tick();
        check("t2_req_once", 32'(req_rd), 32'd0);

        // Both sources streaming: MEM wins three grants, then starvation hands ALU the 4th
        ai = 0; mi = 0;
        exp_q.push_back(wr_t'{a: 8'd2, d: 16'hB0});
        exp_q.push_back(wr_t'{a: 8'd2, d: 16'hB1});
        exp_q.push_back(wr_t'{a: 8'd2, d: 16'hB2});
        exp_q.push_back(wr_t'{a: 8'd1, d: 16'hA0});
        exp_q.push_back(wr_t'{a: 8'd2, d: 16'hB3});
        exp_q.push_back(wr_t'{a: 8'd1, d: 16'hA1});
        for (int i = 0; i < 5; i++) begin
            alu_valid = 1'b1; mem_valid = 1'b1;
            alu_addr = 8'd1; mem_addr = 8'd2;
            alu_data = 16'(16'hA0 + ai);
            mem_data = 16'(16'hB0 + mi);
            #1;
            acc_a = alu_ready; acc_m = mem_ready;
            if (i == 1) check("t3_alu_stalled", 32'(alu_ready), 32'd0);
            if (i == 4) check("t3_alu_turn", 32'(alu_ready), 32'd1);
            tick();
            if (acc_a) ai++;
            if (acc_m) mi++;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (4) tick();
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // Same-edge beats to r4: older MEM first, then ALU
        alu_valid = 1'b1; mem_valid = 1'b1;
        alu_addr = 8'd4; mem_addr = 8'd4;
        alu_data = 16'hAAAA; mem_data = 16'hBBBB;
        exp_q.push_back(wr_t'{a: 8'd4, d: 16'hBBBB});
        exp_q.push_back(wr_t'{a: 8'd4, d: 16'hAAAA});
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0; qry_rs = 8'd4;
        #1;
        check("t4_hazard_held_alu", 32'(hazard_rs), 32'd1);
        tick();
        check("t4_hazard_alu_granted", 32'(hazard_rs), 32'd0);
        repeat (3) tick();
        check("t4_r4_final", 32'(model_rf[4]), 32'hAAAA);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Zero-register alias: accepted, never written, no hazard
        alu_valid = 1'b1; alu_addr = 8'd8; alu_data = 16'hDEAD;
        #1;
        check("t5_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0; qry_rs = 8'd8;
        #1;
        check("t5_hazard_rs", 32'(hazard_rs), 32'd0);
        check("t5_slot_empty", 32'(alu_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_write", 32'(req_rd), 32'd0);
        end

        // Held MEM write to r3 flagged on rt, then flushed without writing
        mem_valid = 1'b1; mem_addr = 8'd3; mem_data = 16'h3333;
        tick();
        mem_valid = 1'b0; flush = 1'b1; qry_rt = 8'd3;
        #1;
        check("t6_hazard_rt", 32'(hazard_rt), 32'd1);
        check("t6_flush_mem_ready", 32'(mem_ready), 32'd0);
        check("t6_flush_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("t6_hazard_cleared", 32'(hazard_rt), 32'd0);
        check("t6_mem_ready", 32'(mem_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t6_no_write", 32'(req_rd), 32'd0);
        end
        check("t6_r3_untouched", 32'(model_rf[3]), 32'd0);

        // Reset mid-traffic: pending write and held beats are discarded
        alu_valid = 1'b1; mem_valid = 1'b1;
        alu_addr = 8'd1; mem_addr = 8'd2;
        alu_data = 16'h1111; mem_data = 16'h2222;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0; qry_rs = 8'd1;
        tick();
        clear_n = 1'b0;
        #1;
        check("t1_req_rd", 32'(req_rd), 32'd0);
        check("t1_wdata", 32'(wdata), 32'd0);
        check("t1_alu_ready", 32'(alu_ready), 32'd0);
        check("t1_mem_ready", 32'(mem_ready), 32'd0);
        check("t1_hazard_rs", 32'(hazard_rs), 32'd0);
        tick();
        clear_n = 1'b1;
        #1;
        check("t1_rel_alu_ready", 32'(alu_ready), 32'd1);
        check("t1_rel_mem_ready", 32'(mem_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_no_write", 32'(req_rd), 32'd0);
        end
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
